// File: rtl/core_pkg.sv
// Shared core types: memory operation and access-size encodings used by the LSU.
package core_pkg;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'd0,
        OP_STORE = 2'd1,
        OP_CAS   = 2'd2
    } mem_op_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } mem_size_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte/halfword lane handling: load extraction with zero/sign extension and
// store-lane merge of right-justified write data into a full memory word.
module lsu_lane_align
    import core_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  mem_size_t        size,
    input  logic             is_signed,
    input  logic [1:0]       lane,
    input  logic [XLEN-1:0]  rdata,
    input  logic [XLEN-1:0]  wdata,
    output logic [XLEN-1:0]  load_data,
    output logic [XLEN-1:0]  store_word
);

    logic [4:0]      shamt;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] mask;
    logic [XLEN-1:0] ins;

    // Select the addressed lane, extend it for loads, and splice new data in for stores.
    always_comb begin
        shamt     = (size == SZ_HALF) ? {lane[1], 4'b0000} : {lane, 3'b000};
        shifted   = rdata >> shamt;
        load_data = rdata;
        mask      = '1;
        ins       = wdata;
        case (size)
            SZ_BYTE: begin
                load_data = {{(XLEN-8){is_signed & shifted[7]}}, shifted[7:0]};
                mask      = XLEN'(8'hFF) << shamt;
                ins       = XLEN'(wdata[7:0]) << shamt;
            end
            SZ_HALF: begin
                load_data = {{(XLEN-16){is_signed & shifted[15]}}, shifted[15:0]};
                mask      = XLEN'(16'hFFFF) << shamt;
                ins       = XLEN'(wdata[15:0]) << shamt;
            end
            default: begin
                load_data = rdata;
                mask      = '1;
                ins       = wdata;
            end
        endcase
        store_word = (rdata & ~mask) | ins;
    end

endmodule

// File: rtl/lsu_mem_port.sv
// LSU-to-scratchpad port: one request in flight, load/store/CAS with alignment
// checks, sub-word load extension and a WAIT-state watchdog.
// Optional macro LSU_SUBWORD_RMW_EN: sub-word stores become read-modify-write;
// without it they complete immediately with an error.
module lsu_mem_port
    import core_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int TAG_W    = 6,
    parameter int WD_LIMIT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  mem_op_t           req_op,
    input  mem_size_t         req_size,
    input  logic              req_signed,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic [XLEN-1:0]   req_cmp,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [TAG_W-1:0]  resp_tag,
    output logic [XLEN-1:0]   resp_data,
    output logic              resp_error,
    output logic              mem_req,
    output logic              mem_we,
    output logic              mem_atomic,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN-1:0]   mem_cmp_val,
    input  logic              mem_ready,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_error
);

`ifdef LSU_SUBWORD_RMW_EN
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RMW_WR, RMW_WAIT, RESP} state_t;
`else
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP} state_t;
`endif

    state_t          state, state_n;
    logic [3:0]      wd_cnt;
    mem_op_t         op_q;
    mem_size_t       size_q;
    logic            signed_q;
    logic [XLEN-1:0] addr_q, wdata_q, cmp_q, merge_q, resp_data_q;
    logic [TAG_W-1:0] tag_q;
    logic            resp_err_q;
    logic            resp_load, resp_err_n, merge_load, misaligned, blocked, in_wait, wd_expired;
    logic [XLEN-1:0] resp_data_n, load_data, store_word;

    assign misaligned = (req_op == OP_CAS && req_size != SZ_WORD) ||
                        (req_size == SZ_HALF && req_addr[0]) ||
                        (req_size == SZ_WORD && req_addr[1:0] != 2'b00);
`ifdef LSU_SUBWORD_RMW_EN
    assign blocked = 1'b0;
    assign in_wait = (state == WAIT) || (state == RMW_WAIT);
`else
    assign blocked = (req_op == OP_STORE) && (req_size != SZ_WORD);
    assign in_wait = (state == WAIT);
`endif
    assign wd_expired = (wd_cnt == 4'(WD_LIMIT - 1));

    lsu_lane_align #(.XLEN(XLEN)) u_align (
        .size       (size_q),
        .is_signed  (signed_q),
        .lane       (addr_q[1:0]),
        .rdata      (mem_rdata),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_word (store_word)
    );

    // Next-state decode plus the response value captured on entry to RESP.
    always_comb begin
        state_n     = state;
        resp_load   = 1'b0;
        resp_err_n  = 1'b0;
        resp_data_n = '0;
        merge_load  = 1'b0;
        case (state)
            IDLE: if (req_valid) begin
                if (misaligned || blocked) begin
                    state_n    = RESP;
                    resp_load  = 1'b1;
                    resp_err_n = 1'b1;
                end else begin
                    state_n = ISSUE;
                end
            end
            ISSUE: if (mem_error) begin
                state_n    = RESP;
                resp_load  = 1'b1;
                resp_err_n = 1'b1;
            end else begin
                state_n = WAIT;
            end
            WAIT: if (mem_ready) begin
`ifdef LSU_SUBWORD_RMW_EN
                if (op_q == OP_STORE && size_q != SZ_WORD) begin
                    state_n    = RMW_WR;
                    merge_load = 1'b1;
                end else
`endif
                begin
                    state_n     = RESP;
                    resp_load   = 1'b1;
                    resp_data_n = (op_q == OP_LOAD) ? load_data :
                                  (op_q == OP_CAS)  ? mem_rdata : '0;
                end
            end else if (wd_expired) begin
                state_n    = RESP;
                resp_load  = 1'b1;
                resp_err_n = 1'b1;
            end
`ifdef LSU_SUBWORD_RMW_EN
            RMW_WR: state_n = RMW_WAIT;
            RMW_WAIT: if (mem_ready || wd_expired) begin
                state_n    = RESP;
                resp_load  = 1'b1;
                resp_err_n = !mem_ready;
            end
`endif
            RESP: if (resp_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Control state: FSM register and watchdog, cleared on every state change.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            wd_cnt <= '0;
        end else begin
            state <= state_n;
            if (state_n != state) wd_cnt <= '0;
            else if (in_wait)     wd_cnt <= wd_cnt + 4'd1;
        end
    end

    // Request fields, RMW merge word and response payload.
    always_ff @(posedge clk) begin
        if (state == IDLE && req_valid) begin
            op_q     <= req_op;
            size_q   <= req_size;
            signed_q <= req_signed;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            cmp_q    <= req_cmp;
            tag_q    <= req_tag;
        end
        if (merge_load) merge_q <= store_word;
        if (resp_load) begin
            resp_data_q <= resp_data_n;
            resp_err_q  <= resp_err_n;
        end
    end

    // Output decode; payload buses are held at zero outside their qualifying state.
    always_comb begin
        req_ready   = (state == IDLE) && !reset;
        resp_valid  = (state == RESP);
        resp_tag    = resp_valid ? tag_q : '0;
        resp_data   = resp_valid ? resp_data_q : '0;
        resp_error  = resp_valid & resp_err_q;
        mem_req     = (state == ISSUE);
        mem_we      = (state == ISSUE) && (op_q == OP_STORE) && (size_q == SZ_WORD);
        mem_atomic  = (state == ISSUE) && (op_q == OP_CAS);
`ifdef LSU_SUBWORD_RMW_EN
        if (state == RMW_WR) begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
        end
`endif
        mem_addr    = mem_req ? {addr_q[XLEN-1:2], 2'b00} : '0;
        mem_wdata   = !mem_req ? '0 :
                      (state == ISSUE) ? ((mem_we || mem_atomic) ? wdata_q : '0) : merge_q;
        mem_cmp_val = mem_atomic ? cmp_q : '0;
    end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Self-checking bench for lsu_mem_port: directed scenarios then random traffic,
// checked against a byte-addressed reference memory model.
module tb_lsu_mem_port;
    import core_pkg::*;

`ifdef LSU_SUBWORD_RMW_EN
    localparam bit RMW = 1'b1;
`else
    localparam bit RMW = 1'b0;
`endif

    logic        clk, reset;
    logic        req_valid, req_ready, req_signed;
    mem_op_t     req_op;
    mem_size_t   req_size;
    logic [31:0] req_addr, req_wdata, req_cmp;
    logic [5:0]  req_tag, resp_tag;
    logic        resp_valid, resp_ready, resp_error;
    logic [31:0] resp_data;
    logic        mem_req, mem_we, mem_atomic, mem_ready, mem_error;
    logic [31:0] mem_addr, mem_wdata, mem_cmp_val, mem_rdata;

    logic        err_arm = 1'b0;
    logic        withhold = 1'b0;
    int          cyc = 0;
    int          mreq_cnt = 0;
    int          total = 0;
    int          bad = 0;
    logic [31:0] spm [0:255];
    logic [7:0]  rbytes [0:1023];

    lsu_mem_port dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_size(req_size),
        .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata), .req_cmp(req_cmp),
        .req_tag(req_tag), .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_tag(resp_tag),
        .resp_data(resp_data), .resp_error(resp_error), .mem_req(mem_req), .mem_we(mem_we),
        .mem_atomic(mem_atomic), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_cmp_val(mem_cmp_val), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .mem_error(mem_error)
    );

    assign mem_error = err_arm & mem_req;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (mem_req) mreq_cnt <= mreq_cnt + 1;

    // Scratchpad: read/write complete one cycle after mem_req, CAS two cycles after.
    initial begin
        logic        seen, we, at;
        logic [31:0] a, wd, cv, old, held;
        int          countdown;
        countdown = 0;
        held = 0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        for (int i = 0; i < 256; i++) spm[i] = '0;
        forever begin
            @(negedge clk);
            seen = mem_req; we = mem_we; at = mem_atomic;
            a = mem_addr; wd = mem_wdata; cv = mem_cmp_val;
            @(posedge clk);
            #1;
            mem_ready = 1'b0;
            mem_rdata = '0;
            if (countdown > 0) begin
                countdown--;
                if (countdown == 0 && !withhold) begin
                    mem_ready = 1'b1;
                    mem_rdata = held;
                end
            end
            if (seen && !err_arm) begin
                old = spm[a[9:2]];
                if (we) spm[a[9:2]] = wd;
                if (at && old == cv) spm[a[9:2]] = wd;
                held = old;
                if (at) countdown = 1;
                else if (!withhold) begin
                    mem_ready = 1'b1;
                    mem_rdata = old;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [31:0] addr);
        int b;
        b = int'({addr[9:2], 2'b00});
        return {rbytes[b+3], rbytes[b+2], rbytes[b+1], rbytes[b]};
    endfunction

    // Reference model: expected response, latency and mem_req count; updates rbytes.
    // fault: 0 none, 1 scratchpad error, 2 scratchpad never completes.
    task automatic model(input mem_op_t op, input mem_size_t sz, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] cmp,
                         input int fault, output logic [31:0] d, output logic e,
                         output int lat, output int pulses);
        int nb, base, v;
        logic [31:0] old;
        nb = (sz == SZ_BYTE) ? 1 : (sz == SZ_HALF) ? 2 : 4;
        base = int'(addr[9:0]);
        d = '0; e = 1'b0; lat = 1; pulses = 0;
        if ((op == OP_CAS && sz != SZ_WORD) || (base % nb) != 0) begin e = 1'b1; return; end
        if (op == OP_STORE && nb < 4 && !RMW) begin e = 1'b1; return; end
        if (fault == 1) begin e = 1'b1; lat = 2; pulses = 1; return; end
        if (fault == 2) begin e = 1'b1; lat = -1; pulses = 1; return; end
        case (op)
            OP_LOAD: begin
                v = 0;
                for (int i = 0; i < nb; i++) v += int'(rbytes[base+i]) << (8 * i);
                if (sgn && nb < 4 && v >= (1 << (8 * nb - 1))) v -= (1 << (8 * nb));
                d = 32'(v); lat = 3; pulses = 1;
            end
            OP_STORE: begin
                for (int i = 0; i < nb; i++) rbytes[base+i] = wd[8*i +: 8];
                lat = (nb == 4) ? 3 : 5;
                pulses = (nb == 4) ? 1 : 2;
            end
            default: begin
                old = ref_word(addr);
                d = old;
                if (old == cmp) for (int i = 0; i < 4; i++) rbytes[base+i] = wd[8*i +: 8];
                lat = 4; pulses = 1;
            end
        endcase
    endtask

    // One complete transaction from the negedge of request presentation to response handshake.
    task automatic txn(input mem_op_t op, input mem_size_t sz, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] cmp,
                       input int fault, input int stall);
        logic [31:0] ed;
        logic        ee;
        int          el, ep, t0, p0;
        logic [5:0]  tag;
        tag = 6'($urandom);
        model(op, sz, sgn, addr, wd, cmp, fault, ed, ee, el, ep);
        req_valid = 1'b1; req_op = op; req_size = sz; req_signed = sgn;
        req_addr = addr; req_wdata = wd; req_cmp = cmp; req_tag = tag;
        p0 = mreq_cnt;
        @(posedge clk);
        @(negedge clk);
        t0 = cyc;
        req_valid = 1'b0;
        while (!resp_valid && (cyc - t0) < 40) @(negedge clk);
        if (el >= 0) check("latency", 32'(cyc - t0 + 1), 32'(el));
        check("resp_valid", {31'b0, resp_valid}, 32'd1);
        check("resp_data", resp_data, ed);
        check("resp_error", {31'b0, resp_error}, {31'b0, ee});
        check("resp_tag", {26'b0, resp_tag}, {26'b0, tag});
        check("mem_req_count", 32'(mreq_cnt - p0), 32'(ep));
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check("hold_valid", {31'b0, resp_valid}, 32'd1);
            check("hold_data", resp_data, ed);
            check("hold_error", {31'b0, resp_error}, {31'b0, ee});
            check("hold_tag", {26'b0, resp_tag}, {26'b0, tag});
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check("resp_released", {31'b0, resp_valid}, 32'd0);
        check("ready_after_resp", {31'b0, req_ready}, 32'd1);
        check("mem_word", spm[addr[9:2]], ref_word(addr));
    endtask

    initial begin
        mem_op_t     rop;
        mem_size_t   rsz;
        logic [31:0] raddr, rcmp;
        int          nb;
        for (int i = 0; i < 1024; i++) rbytes[i] = '0;
        reset = 1'b1; resp_ready = 1'b0;
        req_valid = 1'b0; req_op = OP_LOAD; req_size = SZ_WORD; req_signed = 1'b0;
        req_addr = '0; req_wdata = '0; req_cmp = '0; req_tag = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_req_ready", {31'b0, req_ready}, 32'd0);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_mem_req", {31'b0, mem_req}, 32'd0);
        check("rst_resp_data", resp_data, 32'd0);
        reset = 1'b0;
        #1 check("rel_req_ready", {31'b0, req_ready}, 32'd1);
        @(negedge clk);

        // Word write/read
        txn(OP_STORE, SZ_WORD, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0);
        txn(OP_LOAD,  SZ_WORD, 1'b0, 32'h100, 32'h0, 32'h0, 0, 0);
        // Signed/unsigned byte
        txn(OP_STORE, SZ_WORD, 1'b0, 32'h100, 32'h80FF1234, 32'h0, 0, 0);
        txn(OP_LOAD,  SZ_BYTE, 1'b1, 32'h103, 32'h0, 32'h0, 0, 0);
        txn(OP_LOAD,  SZ_BYTE, 1'b0, 32'h103, 32'h0, 32'h0, 0, 0);
        // Sub-word store
        txn(OP_STORE, SZ_WORD, 1'b0, 32'h100, 32'h11223344, 32'h0, 0, 0);
        txn(OP_STORE, SZ_HALF, 1'b0, 32'h102, 32'h0000ABCD, 32'h0, 0, 0);
        // CAS hit then miss
        txn(OP_STORE, SZ_WORD, 1'b0, 32'h100, 32'hABCD3344, 32'h0, 0, 0);
        txn(OP_CAS,   SZ_WORD, 1'b0, 32'h100, 32'h5, 32'hABCD3344, 0, 0);
        txn(OP_CAS,   SZ_WORD, 1'b0, 32'h100, 32'h7, 32'hABCD3344, 0, 0);
        // Misaligned word load, scratchpad error, watchdog, held response
        txn(OP_LOAD,  SZ_WORD, 1'b0, 32'h102, 32'h0, 32'h0, 0, 0);
        err_arm = 1'b1;
        txn(OP_LOAD,  SZ_WORD, 1'b0, 32'h104, 32'h0, 32'h0, 1, 0);
        err_arm = 1'b0;
        withhold = 1'b1;
        txn(OP_LOAD,  SZ_WORD, 1'b0, 32'h100, 32'h0, 32'h0, 2, 0);
        withhold = 1'b0;
        txn(OP_LOAD,  SZ_HALF, 1'b1, 32'h102, 32'h0, 32'h0, 0, 3);

        // Reset while waiting for the scratchpad
        withhold = 1'b1;
        req_valid = 1'b1; req_op = OP_LOAD; req_size = SZ_WORD; req_addr = 32'h100; req_tag = 6'h2A;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check("midrst_req_ready", {31'b0, req_ready}, 32'd0);
        check("midrst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("midrst_mem_req", {31'b0, mem_req}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        withhold = 1'b0;
        #1 check("postrst_req_ready", {31'b0, req_ready}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("postrst_no_resp", {31'b0, resp_valid}, 32'd0);
        end

        // Random traffic
        for (int n = 0; n < 60; n++) begin
            rop = mem_op_t'($urandom_range(0, 2));
            rsz = mem_size_t'($urandom_range(0, 2));
            if (rop == OP_CAS && $urandom_range(0, 4) != 0) rsz = SZ_WORD;
            nb = (rsz == SZ_BYTE) ? 1 : (rsz == SZ_HALF) ? 2 : 4;
            raddr = 32'h100 + 32'($urandom_range(0, 15));
            if ($urandom_range(0, 4) != 0) raddr = raddr & ~32'(nb - 1);
            rcmp = ($urandom_range(0, 1) == 1) ? ref_word(raddr) : $urandom;
            txn(rop, rsz, 1'($urandom_range(0, 1)), raddr, $urandom, rcmp, 0,
                $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
